// File: rtl/compressed_fetch_aligner.sv
// compressed_fetch_aligner: halfword fetch buffer, 32-bit realignment
// and RV32C expansion between instruction memory and decode.
module compressed_fetch_aligner #(
    parameter int BUF_HALFWORDS = 6,
    parameter int ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
    parameter bit RVC_EN = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_valid,
    output logic                  fetch_ready,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    input  logic [31:0]           fetch_data,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_instruction,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic                  out_is_compressed,
    output logic                  out_illegal
);

    localparam int PW = $clog2(BUF_HALFWORDS);
    localparam int CW = $clog2(BUF_HALFWORDS + 1);
    localparam logic [CW-1:0] DEPTH = CW'(BUF_HALFWORDS);
    localparam logic [PW-1:0] LAST = PW'(BUF_HALFWORDS - 1);

    logic [15:0]           buf_data [BUF_HALFWORDS];
    logic [ADDR_WIDTH-1:0] buf_pc   [BUF_HALFWORDS];

    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;
    logic [CW-1:0]         count;
    logic [ADDR_WIDTH-1:0] expected_pc;
    logic                  skip_low;

    logic [PW-1:0]         rd_ptr1;
    logic [PW-1:0]         wr_ptr1;
    logic [PW-1:0]         rd_next;
    logic [PW-1:0]         wr_next;
    logic [15:0]           h0;
    logic [15:0]           h1;
    logic                  head_comp;
    logic                  head_valid;
    logic [CW-1:0]         free_cnt;
    logic                  accept;
    logic                  stale;
    logic                  push;
    logic                  fire;
    logic [1:0]            push_n;
    logic [1:0]            pop_n;
    logic [ADDR_WIDTH-1:0] word_pc;
    logic [ADDR_WIDTH-1:0] high_pc;

    logic [31:0]           exp_instr;
    logic                  exp_ill;

    logic                  unused_bits;
    assign unused_bits = ^{fetch_addr[1:0], redirect_pc[0],
                           expected_pc[1:0]};

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == LAST) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign rd_ptr1 = ptr_inc(rd_ptr);
    assign wr_ptr1 = ptr_inc(wr_ptr);
    assign h0 = buf_data[rd_ptr];
    assign h1 = buf_data[rd_ptr1];

    assign head_comp = (h0[1:0] != 2'b11);
    assign head_valid = head_comp ? (count >= CW'(1))
                                  : (count >= CW'(2));

    assign free_cnt = DEPTH - count;
    assign fetch_ready = !rst && (free_cnt >= CW'(2));
    assign accept = fetch_valid && fetch_ready;
    assign stale = fetch_addr[ADDR_WIDTH-1:2]
                != expected_pc[ADDR_WIDTH-1:2];
    assign push = accept && !stale && !redirect;
    assign push_n = !push ? 2'd0 : (skip_low ? 2'd1 : 2'd2);

    assign out_valid = !rst && head_valid;
    assign fire = out_valid && out_ready;
    assign pop_n = !fire ? 2'd0 : (head_comp ? 2'd1 : 2'd2);

    assign word_pc = {fetch_addr[ADDR_WIDTH-1:2], 2'b00};
    assign high_pc = {fetch_addr[ADDR_WIDTH-1:2], 2'b10};

    // Next read/write pointers after the pop and push of this cycle.
    always_comb begin
        rd_next = rd_ptr;
        wr_next = wr_ptr;
        unique case (pop_n)
            2'd1:    rd_next = rd_ptr1;
            2'd2:    rd_next = ptr_inc(rd_ptr1);
            default: rd_next = rd_ptr;
        endcase
        unique case (push_n)
            2'd1:    wr_next = wr_ptr1;
            2'd2:    wr_next = ptr_inc(wr_ptr1);
            default: wr_next = wr_ptr;
        endcase
    end

    // Buffer control state; redirect flushes and overrides push/pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            expected_pc <= {RESET_PC[ADDR_WIDTH-1:1], 1'b0};
            skip_low    <= RESET_PC[1];
        end else if (redirect) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            expected_pc <= {redirect_pc[ADDR_WIDTH-1:1], 1'b0};
            skip_low    <= redirect_pc[1];
        end else begin
            rd_ptr <= rd_next;
            wr_ptr <= wr_next;
            count  <= count + CW'(push_n) - CW'(pop_n);
            if (push) begin
                expected_pc <= word_pc + ADDR_WIDTH'(4);
                skip_low    <= 1'b0;
            end
        end
    end

    // Halfword storage; a skipped low half leaves only the high half.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            if (skip_low) begin
                buf_data[wr_ptr] <= fetch_data[31:16];
                buf_pc[wr_ptr]   <= high_pc;
            end else begin
                buf_data[wr_ptr]  <= fetch_data[15:0];
                buf_pc[wr_ptr]    <= word_pc;
                buf_data[wr_ptr1] <= fetch_data[31:16];
                buf_pc[wr_ptr1]   <= high_pc;
            end
        end
    end

    logic [4:0]  rd_f;
    logic [4:0]  rs2_f;
    logic [4:0]  rdp;
    logic [4:0]  rs2p;
    logic [11:0] imm6_s;
    logic [5:0]  imm6;
    logic [19:0] j_hi;
    logic [6:0]  b_hi;
    logic [4:0]  b_lo;
    logic [4:0]  op;

    assign rd_f   = h0[11:7];
    assign rs2_f  = h0[6:2];
    assign rdp    = {2'b01, h0[9:7]};
    assign rs2p   = {2'b01, h0[4:2]};
    assign imm6   = {h0[12], h0[6:2]};
    assign imm6_s = {{6{h0[12]}}, imm6};
    assign j_hi   = {h0[12], h0[8], h0[10:9], h0[6], h0[7],
                     h0[2], h0[11], h0[5:3], h0[12],
                     {8{h0[12]}}};
    assign b_hi   = {h0[12], {3{h0[12]}}, h0[6:5], h0[2]};
    assign b_lo   = {h0[11:10], h0[4:3], h0[12]};
    assign op     = {h0[1:0], h0[15:13]};

    // RV32C expansion of the head halfword plus illegal detection.
    always_comb begin
        exp_instr = '0;
        exp_ill   = 1'b0;
        unique case (op)
            5'b00_000: begin
                exp_instr = {2'b00, h0[10:7], h0[12:11], h0[5],
                             h0[6], 2'b00, 5'd2, 3'b000, rs2p,
                             7'h13};
                exp_ill = (h0[12:5] == 8'h00);
            end
            5'b00_010: begin
                exp_instr = {5'b0, h0[5], h0[12:10], h0[6], 2'b00,
                             rdp, 3'b010, rs2p, 7'h03};
            end
            5'b00_110: begin
                exp_instr = {5'b0, h0[5], h0[12], rs2p, rdp,
                             3'b010, h0[11:10], h0[6], 2'b00,
                             7'h23};
            end
            5'b01_000: begin
                exp_instr = {imm6_s, rd_f, 3'b000, rd_f, 7'h13};
            end
            5'b01_001: begin
                exp_instr = {j_hi, 5'd1, 7'h6f};
            end
            5'b01_010: begin
                exp_instr = {imm6_s, 5'd0, 3'b000, rd_f, 7'h13};
            end
            5'b01_011: begin
                exp_ill = (imm6 == 6'd0);
                if (rd_f == 5'd2) begin
                    exp_instr = {{3{h0[12]}}, h0[4:3], h0[5],
                                 h0[2], h0[6], 4'b0000, 5'd2,
                                 3'b000, 5'd2, 7'h13};
                end else begin
                    exp_instr = {{15{h0[12]}}, h0[6:2], rd_f,
                                 7'h37};
                end
            end
            5'b01_100: begin
                case (h0[11:10])
                    2'b00: begin
                        exp_instr = {7'b0, h0[6:2], rdp, 3'b101,
                                     rdp, 7'h13};
                        exp_ill = h0[12];
                    end
                    2'b01: begin
                        exp_instr = {7'b0100000, h0[6:2], rdp,
                                     3'b101, rdp, 7'h13};
                        exp_ill = h0[12];
                    end
                    2'b10: begin
                        exp_instr = {imm6_s, rdp, 3'b111, rdp,
                                     7'h13};
                    end
                    default: begin
                        exp_ill = h0[12];
                        case (h0[6:5])
                            2'b00: exp_instr = {7'b0100000, rs2p,
                                                rdp, 3'b000, rdp,
                                                7'h33};
                            2'b01: exp_instr = {7'b0, rs2p, rdp,
                                                3'b100, rdp, 7'h33};
                            2'b10: exp_instr = {7'b0, rs2p, rdp,
                                                3'b110, rdp, 7'h33};
                            default: exp_instr = {7'b0, rs2p, rdp,
                                                  3'b111, rdp,
                                                  7'h33};
                        endcase
                    end
                endcase
            end
            5'b01_101: begin
                exp_instr = {j_hi, 5'd0, 7'h6f};
            end
            5'b01_110: begin
                exp_instr = {b_hi, 5'd0, rdp, 3'b000, b_lo, 7'h63};
            end
            5'b01_111: begin
                exp_instr = {b_hi, 5'd0, rdp, 3'b001, b_lo, 7'h63};
            end
            5'b10_000: begin
                exp_instr = {7'b0, h0[6:2], rd_f, 3'b001, rd_f,
                             7'h13};
                exp_ill = h0[12];
            end
            5'b10_010: begin
                exp_instr = {4'b0, h0[3:2], h0[12], h0[6:4], 2'b00,
                             5'd2, 3'b010, rd_f, 7'h03};
                exp_ill = (rd_f == 5'd0);
            end
            5'b10_100: begin
                if (!h0[12]) begin
                    if (rs2_f == 5'd0) begin
                        exp_instr = {12'b0, rd_f, 3'b000, 5'd0,
                                     7'h67};
                        exp_ill = (rd_f == 5'd0);
                    end else begin
                        exp_instr = {7'b0, rs2_f, 5'd0, 3'b000,
                                     rd_f, 7'h33};
                    end
                end else if (rs2_f == 5'd0 && rd_f == 5'd0) begin
                    exp_instr = 32'h0010_0073;
                end else if (rs2_f == 5'd0) begin
                    exp_instr = {12'b0, rd_f, 3'b000, 5'd1, 7'h67};
                end else begin
                    exp_instr = {7'b0, rs2_f, rd_f, 3'b000, rd_f,
                                 7'h33};
                end
            end
            5'b10_110: begin
                exp_instr = {4'b0, h0[8:7], h0[12], rs2_f, 5'd2,
                             3'b010, h0[11:9], 2'b00, 7'h23};
            end
            default: begin
                exp_ill = 1'b1;
            end
        endcase
        if (!RVC_EN || h0 == 16'h0000) begin
            exp_ill = 1'b1;
        end
    end

    // Output mux from the registered head; zero when nothing is valid.
    always_comb begin
        out_instruction   = '0;
        out_pc            = '0;
        out_is_compressed = 1'b0;
        out_illegal       = 1'b0;
        if (out_valid) begin
            out_pc            = buf_pc[rd_ptr];
            out_is_compressed = head_comp;
            if (!head_comp) begin
                out_instruction = {h1, h0};
            end else if (exp_ill) begin
                out_illegal     = 1'b1;
                out_instruction = {16'h0000, h0};
            end else begin
                out_instruction = exp_instr;
            end
        end
    end

endmodule

// File: tb/tb_compressed_fetch_aligner.sv
// Self-checking bench for compressed_fetch_aligner: directed cases
// plus randomized programs checked against a behavioural model.
module tb_compressed_fetch_aligner;

    logic        clk;
    logic        rst;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_addr;
    logic [31:0] fetch_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instruction;
    logic [31:0] out_pc;
    logic        out_is_compressed;
    logic        out_illegal;

    int total = 0;
    int bad = 0;

    compressed_fetch_aligner #(
        .BUF_HALFWORDS(6),
        .ADDR_WIDTH(32),
        .RESET_PC(32'h0),
        .RVC_EN(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .fetch_valid(fetch_valid),
        .fetch_ready(fetch_ready),
        .fetch_addr(fetch_addr),
        .fetch_data(fetch_data),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_instruction(out_instruction),
        .out_pc(out_pc),
        .out_is_compressed(out_is_compressed),
        .out_illegal(out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] pc;
        logic        comp;
        logic        ill;
    } exp_t;

    function automatic int fld(input logic [15:0] c, input int hi,
                               input int lo);
        return int'((c >> lo) & ((1 << (hi - lo + 1)) - 1));
    endfunction

    function automatic logic [31:0] enc_i(input int imm, input int rs1,
                                          input int f3, input int rd,
                                          input int opc);
        logic [31:0] v;
        v = imm;
        return {v[11:0], rs1[4:0], f3[2:0], rd[4:0], opc[6:0]};
    endfunction

    function automatic logic [31:0] enc_s(input int imm, input int rs2,
                                          input int rs1, input int f3,
                                          input int opc);
        logic [31:0] v;
        v = imm;
        return {v[11:5], rs2[4:0], rs1[4:0], f3[2:0], v[4:0],
                opc[6:0]};
    endfunction

    function automatic logic [31:0] enc_r(input int f7, input int rs2,
                                          input int rs1, input int f3,
                                          input int rd, input int opc);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0],
                opc[6:0]};
    endfunction

    function automatic logic [31:0] enc_b(input int imm, input int rs1,
                                          input int f3);
        logic [31:0] v;
        v = imm;
        return {v[12], v[10:5], 5'd0, rs1[4:0], f3[2:0], v[4:1],
                v[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_j(input int imm, input int rd);
        logic [31:0] v;
        v = imm;
        return {v[20], v[10:1], v[11], v[19:12], rd[4:0], 7'h6f};
    endfunction

    function automatic logic [31:0] enc_u(input int imm, input int rd);
        logic [31:0] v;
        v = imm;
        return {v[19:0], rd[4:0], 7'h37};
    endfunction

    // Reference RV32C expansion: returns {illegal, instruction}.
    function automatic logic [32:0] ref_expand(input logic [15:0] c);
        int q, f3, rd, rs2, rdp, rs2p, b12, u6, s6, o, so, sh;
        int f3tab[4];
        logic ill;
        logic [31:0] ins;
        f3tab = '{0, 4, 6, 7};
        q = fld(c, 1, 0);
        f3 = fld(c, 15, 13);
        rd = fld(c, 11, 7);
        rs2 = fld(c, 6, 2);
        rdp = 8 + fld(c, 9, 7);
        rs2p = 8 + fld(c, 4, 2);
        b12 = fld(c, 12, 12);
        u6 = rs2 + 32 * b12;
        s6 = b12 ? u6 - 64 : u6;
        sh = rs2;
        ill = 1'b0;
        ins = 32'h0;
        if (q == 0) begin
            o = fld(c, 5, 5) * 64 + fld(c, 12, 10) * 8
              + fld(c, 6, 6) * 4;
            if (f3 == 0) begin
                so = fld(c, 5, 5) * 8 + fld(c, 6, 6) * 4
                   + fld(c, 12, 11) * 16 + fld(c, 10, 7) * 64;
                ill = (so == 0);
                ins = enc_i(so, 2, 0, rs2p, 'h13);
            end else if (f3 == 2) begin
                ins = enc_i(o, rdp, 2, rs2p, 'h03);
            end else if (f3 == 6) begin
                ins = enc_s(o, rs2p, rdp, 2, 'h23);
            end else begin
                ill = 1'b1;
            end
        end else if (q == 1) begin
            o = b12 * 2048 + fld(c, 11, 11) * 16
              + fld(c, 10, 9) * 256 + fld(c, 8, 8) * 1024
              + fld(c, 7, 7) * 64 + fld(c, 6, 6) * 128
              + fld(c, 5, 3) * 2 + fld(c, 2, 2) * 32;
            so = b12 ? o - 4096 : o;
            case (f3)
                0: ins = enc_i(s6, rd, 0, rd, 'h13);
                1: ins = enc_j(so, 1);
                2: ins = enc_i(s6, 0, 0, rd, 'h13);
                3: begin
                    ill = (u6 == 0);
                    if (rd == 2) begin
                        o = b12 * 512 + fld(c, 4, 3) * 128
                          + fld(c, 5, 5) * 64 + fld(c, 2, 2) * 32
                          + fld(c, 6, 6) * 16;
                        ins = enc_i(b12 ? o - 1024 : o, 2, 0, 2, 'h13);
                    end else begin
                        ins = enc_u(s6, rd);
                    end
                end
                4: begin
                    case (fld(c, 11, 10))
                        0: begin
                            ill = (b12 == 1);
                            ins = enc_i(sh, rdp, 5, rdp, 'h13);
                        end
                        1: begin
                            ill = (b12 == 1);
                            ins = enc_i(1024 + sh, rdp, 5, rdp, 'h13);
                        end
                        2: ins = enc_i(s6, rdp, 7, rdp, 'h13);
                        default: begin
                            ill = (b12 == 1);
                            o = fld(c, 6, 5);
                            ins = enc_r(o == 0 ? 32 : 0, rs2p, rdp,
                                        f3tab[o], rdp, 'h33);
                        end
                    endcase
                end
                5: ins = enc_j(so, 0);
                default: begin
                    o = b12 * 256 + fld(c, 6, 5) * 64
                      + fld(c, 2, 2) * 32 + fld(c, 11, 10) * 8
                      + fld(c, 4, 3) * 2;
                    ins = enc_b(b12 ? o - 512 : o, rdp,
                                f3 == 6 ? 0 : 1);
                end
            endcase
        end else begin
            if (f3 == 0) begin
                ill = (b12 == 1);
                ins = enc_i(sh, rd, 1, rd, 'h13);
            end else if (f3 == 2) begin
                o = b12 * 32 + fld(c, 6, 4) * 4 + fld(c, 3, 2) * 64;
                ill = (rd == 0);
                ins = enc_i(o, 2, 2, rd, 'h03);
            end else if (f3 == 4) begin
                if (b12 == 0 && rs2 == 0) begin
                    ill = (rd == 0);
                    ins = enc_i(0, rd, 0, 0, 'h67);
                end else if (b12 == 0) begin
                    ins = enc_r(0, rs2, 0, 0, rd, 'h33);
                end else if (rs2 == 0 && rd == 0) begin
                    ins = 32'h0010_0073;
                end else if (rs2 == 0) begin
                    ins = enc_i(0, rd, 0, 1, 'h67);
                end else begin
                    ins = enc_r(0, rs2, rd, 0, rd, 'h33);
                end
            end else if (f3 == 6) begin
                o = fld(c, 12, 9) * 4 + fld(c, 8, 7) * 64;
                ins = enc_s(o, rs2, 2, 2, 'h23);
            end else begin
                ill = 1'b1;
            end
        end
        if (c == 16'h0000) ill = 1'b1;
        if (ill) ins = {16'h0000, c};
        return {ill, ins};
    endfunction

    task automatic do_redirect(input logic [31:0] pc);
        redirect = 1'b1;
        redirect_pc = pc;
        fetch_valid = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        redirect = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] a, input logic [31:0] d);
        bit acc;
        acc = 1'b0;
        fetch_valid = 1'b1;
        fetch_addr = a;
        fetch_data = d;
        for (int n = 0; n < 50 && !acc; n++) begin
            @(negedge clk);
            acc = fetch_ready;
            @(posedge clk);
            #1;
        end
        fetch_valid = 1'b0;
        total++;
        if (!acc) begin
            bad++;
            $display("FAIL push_timeout addr=%h got=no_accept exp=accept",
                     a);
        end
    endtask

    task automatic pop_out(output bit got, output exp_t o);
        got = 1'b0;
        o = '0;
        out_ready = 1'b1;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clk);
            if (out_valid) begin
                got = 1'b1;
                o = '{out_instruction, out_pc, out_is_compressed,
                      out_illegal};
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        fetch_valid = 1'b0;
        fetch_addr = '0;
        fetch_data = '0;
        redirect = 1'b0;
        redirect_pc = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        total++;
        if ({out_valid, fetch_ready} !== 2'b00) begin
            bad++;
            $display("FAIL reset_hs got=%b exp=00",
                     {out_valid, fetch_ready});
        end
        total++;
        if ({out_instruction, out_pc, out_is_compressed, out_illegal}
            !== 66'h0) begin
            bad++;
            $display("FAIL reset_outs got=%h/%h/%b/%b exp=0",
                     out_instruction, out_pc, out_is_compressed,
                     out_illegal);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({fetch_ready, out_valid} !== 2'b10) begin
            bad++;
            $display("FAIL post_reset got=%b exp=10",
                     {fetch_ready, out_valid});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_passthrough();
        fetch_valid = 1'b1;
        fetch_addr = 32'h0;
        fetch_data = 32'h00A0_0093;
        @(negedge clk);
        total++;
        if ({fetch_ready, out_valid} !== 2'b10) begin
            bad++;
            $display("FAIL pass_accept got=%b exp=10",
                     {fetch_ready, out_valid});
        end
        @(posedge clk);
        #1;
        fetch_valid = 1'b0;
        @(negedge clk);
        total++;
        if ({out_valid, out_instruction, out_pc, out_is_compressed,
             out_illegal} !== {1'b1, 32'h00A0_0093, 32'h0, 2'b00}) begin
            bad++;
            $display("FAIL pass_out got=%b/%h/%h/%b exp=1/00a00093/0/0",
                     out_valid, out_instruction, out_pc,
                     out_is_compressed);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL pass_drain got=%b exp=0", out_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_compressed_pair();
        bit got;
        exp_t o;
        do_redirect(32'h0);
        push_word(32'h0, 32'h4505_4501);
        pop_out(got, o);
        total++;
        if ({got, o} !== {1'b1, 32'h0000_0513, 32'h0, 2'b10}) begin
            bad++;
            $display("FAIL cpair_0 got=%b/%h/%h/%b/%b exp=00000513@0",
                     got, o.ins, o.pc, o.comp, o.ill);
        end
        pop_out(got, o);
        total++;
        if ({got, o} !== {1'b1, 32'h0010_0513, 32'h2, 2'b10}) begin
            bad++;
            $display("FAIL cpair_1 got=%b/%h/%h/%b/%b exp=00100513@2",
                     got, o.ins, o.pc, o.comp, o.ill);
        end
    endtask

    task automatic test_straddle();
        bit got;
        exp_t o;
        bit early;
        do_redirect(32'h0);
        push_word(32'h0, 32'h0093_4501);
        pop_out(got, o);
        total++;
        if ({got, o} !== {1'b1, 32'h0000_0513, 32'h0, 2'b10}) begin
            bad++;
            $display("FAIL strad_0 got=%b/%h/%h exp=00000513@0",
                     got, o.ins, o.pc);
        end
        early = 1'b0;
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (out_valid) early = 1'b1;
            @(posedge clk);
            #1;
        end
        out_ready = 1'b0;
        total++;
        if (early) begin
            bad++;
            $display("FAIL strad_early got=valid exp=no_output");
        end
        push_word(32'h4, 32'h4505_00A0);
        pop_out(got, o);
        total++;
        if ({got, o} !== {1'b1, 32'h00A0_0093, 32'h2, 2'b00}) begin
            bad++;
            $display("FAIL strad_1 got=%b/%h/%h/%b exp=00a00093@2",
                     got, o.ins, o.pc, o.comp);
        end
        pop_out(got, o);
        total++;
        if ({got, o} !== {1'b1, 32'h0010_0513, 32'h6, 2'b10}) begin
            bad++;
            $display("FAIL strad_2 got=%b/%h/%h exp=00100513@6",
                     got, o.ins, o.pc);
        end
    endtask

    task automatic test_redirect_stale();
        bit got;
        exp_t o;
        do_redirect(32'h102);
        push_word(32'h8, 32'h1234_5678);
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL stale_drop got=%b exp=0", out_valid);
        end
        @(posedge clk);
        #1;
        push_word(32'h100, 32'h4505_FFFF);
        pop_out(got, o);
        total++;
        if ({got, o} !== {1'b1, 32'h0010_0513, 32'h102, 2'b10}) begin
            bad++;
            $display("FAIL redir_out got=%b/%h/%h exp=00100513@102",
                     got, o.ins, o.pc);
        end
        out_ready = 1'b1;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL redir_single got=%b exp=0", out_valid);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_illegal_backpressure();
        int cnt;
        bit acc;
        logic [31:0] a;
        do_redirect(32'h200);
        cnt = 0;
        a = 32'h200;
        fetch_valid = 1'b1;
        fetch_addr = a;
        fetch_data = 32'h4501_0000;
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(negedge clk);
            total++;
            if (fetch_ready !== ((6 - cnt) >= 2)) begin
                bad++;
                $display("FAIL bp_ready cyc=%0d got=%b exp=%b", cyc,
                         fetch_ready, (6 - cnt) >= 2);
            end
            if (cyc > 0) begin
                total++;
                if ({out_valid, out_illegal, out_instruction, out_pc,
                     out_is_compressed}
                    !== {2'b11, 32'h0, 32'h200, 1'b1}) begin
                    bad++;
                    $display("FAIL bp_hold cyc=%0d got=%b/%b/%h/%h exp=1/1/0/200",
                             cyc, out_valid, out_illegal,
                             out_instruction, out_pc);
                end
            end
            acc = fetch_valid && fetch_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                cnt += 2;
                a += 4;
                fetch_addr = a;
                fetch_data = 32'h4505_4505;
            end
        end
        fetch_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        total++;
        if ({out_valid, out_instruction, out_pc, out_is_compressed,
             out_illegal} !== {1'b1, 32'h0000_0513, 32'h202, 2'b10}) begin
            bad++;
            $display("FAIL bp_next got=%b/%h/%h exp=1/00000513/202",
                     out_valid, out_instruction, out_pc);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        localparam int NW = 20;
        logic [15:0] mem [2*NW];
        exp_t q[$];
        exp_t e;
        exp_t held;
        logic [32:0] r;
        logic [31:0] base;
        logic [15:0] v;
        int s, i, wi, k, cyc;
        bit cur_stale, stall, fire, acc;
        for (int round = 0; round < 6; round++) begin
            base = 32'h1000 + 32'(round) * 32'h100;
            for (int m = 0; m < 2 * NW; m++) begin
                k = $urandom_range(0, 9);
                v = 16'($urandom);
                if (k < 6) v[1:0] = 2'(k % 3);
                else if (k < 9) v[1:0] = 2'b11;
                else v = 16'h0000;
                mem[m] = v;
            end
            s = $urandom_range(0, 3);
            q.delete();
            i = s;
            while (i < 2 * NW) begin
                if (mem[i][1:0] != 2'b11) begin
                    r = ref_expand(mem[i]);
                    q.push_back('{r[31:0], base + 32'(2 * i), 1'b1,
                                  r[32]});
                    i++;
                end else if (i + 1 < 2 * NW) begin
                    q.push_back('{{mem[i+1], mem[i]}, base + 32'(2 * i),
                                  1'b0, 1'b0});
                    i += 2;
                end else begin
                    break;
                end
            end
            do_redirect(base + 32'(2 * s));
            wi = s / 2;
            stall = 1'b0;
            held = '0;
            cyc = 0;
            while (cyc < 3000 && (wi < NW || q.size() != 0)) begin
                cyc++;
                cur_stale = 1'b0;
                fetch_valid = 1'b0;
                if (wi < NW) begin
                    fetch_valid = ($urandom_range(0, 3) != 0);
                    cur_stale = ($urandom_range(0, 7) == 0);
                    fetch_addr = base + 32'(4 * wi)
                               + (cur_stale ? 32'h800 : 32'h0);
                    fetch_data = {mem[2*wi+1], mem[2*wi]};
                end
                out_ready = ($urandom_range(0, 2) != 0);
                @(negedge clk);
                if (stall) begin
                    total++;
                    if ({out_valid, out_instruction, out_pc,
                         out_is_compressed, out_illegal}
                        !== {1'b1, held}) begin
                        bad++;
                        $display("FAIL rand_stable pc=%h got=%h exp=%h",
                                 held.pc, out_instruction, held.ins);
                    end
                end
                fire = out_valid && out_ready;
                stall = out_valid && !out_ready;
                held = '{out_instruction, out_pc, out_is_compressed,
                         out_illegal};
                if (fire) begin
                    total++;
                    if (q.size() == 0) begin
                        bad++;
                        $display("FAIL rand_extra got=%h@%h exp=none",
                                 out_instruction, out_pc);
                    end else begin
                        e = q.pop_front();
                        if (held !== e) begin
                            bad++;
                            $display("FAIL rand_out got=%h@%h c%b i%b exp=%h@%h c%b i%b",
                                     held.ins, held.pc, held.comp,
                                     held.ill, e.ins, e.pc, e.comp,
                                     e.ill);
                        end
                    end
                end
                acc = fetch_valid && fetch_ready && !cur_stale;
                @(posedge clk);
                #1;
                if (acc) wi++;
            end
            fetch_valid = 1'b0;
            total++;
            if (q.size() != 0 || wi < NW) begin
                bad++;
                $display("FAIL rand_timeout round=%0d got=%0d_left exp=0",
                         round, q.size());
            end
            out_ready = 1'b1;
            fire = 1'b0;
            repeat (4) begin
                @(negedge clk);
                if (out_valid) fire = 1'b1;
                @(posedge clk);
                #1;
            end
            out_ready = 1'b0;
            total++;
            if (fire) begin
                bad++;
                $display("FAIL rand_tail round=%0d got=valid exp=idle",
                         round);
            end
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_compressed_pair();
        test_straddle();
        test_redirect_stale();
        test_illegal_backpressure();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/compressed_fetch_aligner.md
# compressed_fetch_aligner

Sits between instruction memory and decode. Accepts word-aligned 32-bit fetch words, buffers them as halfwords, realigns 32-bit instructions that straddle word boundaries, and expands RV32C encodings to their 32-bit equivalents. It emits one instruction per cycle with its PC, a compressed flag and an illegal flag. Successor to the single-word combinational expander: it adds buffering, misalignment, redirect/flush, backpressure, a full RV32C integer subset and illegal detection.

## Interface
- `BUF_HALFWORDS`, default 6: halfword buffer depth; must be at least 4.
- `ADDR_WIDTH`, default 32: PC width.
- `RESET_PC`, default 0: expected PC after reset; halfword aligned.
- `RVC_EN`, default 1: 0 makes every compressed encoding illegal.
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `fetch_valid` in 1: fetch word present.
- `fetch_ready` out 1: block accepts the fetch word this cycle.
- `fetch_addr` in ADDR_WIDTH: word address of `fetch_data`; bits [1:0] are ignored.
- `fetch_data` in 32: little-endian fetch word; the low halfword is at `fetch_addr`.
- `redirect` in 1: flush and restart at `redirect_pc`.
- `redirect_pc` in ADDR_WIDTH: new PC; bit 0 is ignored.
- `out_valid` out 1: instruction valid.
- `out_ready` in 1: consumer takes the instruction.
- `out_instruction` out 32: expanded or passthrough instruction.
- `out_pc` out ADDR_WIDTH: PC of the instruction.
- `out_is_compressed` out 1: source was 16-bit.
- `out_illegal` out 1: illegal or reserved encoding.

## Operation
- **Buffer.** Circular FIFO of `BUF_HALFWORDS` entries, each {data16, pc}. Registers: `count`, read pointer, write pointer, `expected_pc`, `skip_low`.
- **Fetch handshake.**
  - `fetch_ready` = !rst && (free entries >= 2), evaluated on the current `count`. A pop in the same cycle does not free entries.
  - A word is accepted when `fetch_valid && fetch_ready`.
  - An accepted word is stale when `fetch_addr[ADDR_WIDTH-1:2] != expected_pc[ADDR_WIDTH-1:2]`. Stale words are dropped and `fetch_ready` is still asserted for them, so in-flight fetches drain.
  - A matching word pushes both halfwords, low first, with pc and pc+2. When `skip_low`=1 only the high halfword is pushed and `skip_low` is cleared.
  - `expected_pc` advances to the next word address on every non-stale accept.
- **Head decode.** The head halfword h0 is compressed when h0[1:0] != 2'b11.
  - Compressed: needs 1 entry.
  - 32-bit: needs 2 entries; `out_instruction` = {h1, h0}.
  - `out_valid` = entries needed <= `count`.
- **Pop.** On `out_valid && out_ready`, pop 1 or 2 entries.
- **Expansion coverage (RV32C integer subset):**
  - Quadrant 0: C.ADDI4SPN, C.LW, C.SW.
  - Quadrant 1: C.NOP/C.ADDI, C.JAL, C.LI, C.ADDI16SP, C.LUI, C.SRLI, C.SRAI, C.ANDI, C.SUB, C.XOR, C.OR, C.AND, C.J, C.BEQZ, C.BNEZ.
  - Quadrant 2: C.SLLI, C.LWSP, C.JR, C.MV, C.EBREAK, C.JALR, C.ADD, C.SWSP.
  - Immediates are sign-extended per the ISA. C.MV expands to `add rd, x0, rs2`. Every expanded field is bit-exact to the ISA expansion.
- **Illegal encodings:**
  - h0 = 0x0000.
  - C.ADDI4SPN with nzuimm=0.
  - C.ADDI16SP with imm=0.
  - C.LUI with imm=0.
  - C.LWSP with rd=0.
  - C.JR with rs1=0.
  - Shifts with shamt[5]=1.
  - Any FP or RV64-only encoding.
  - Any compressed encoding when `RVC_EN`=0.
  
  An illegal entry outputs `out_illegal`=1 and `out_instruction` = {16'h0, h0}, and pops exactly 1 entry. `out_illegal`=0 for all 32-bit instructions.
- **Redirect.** On `redirect`: `count`←0, pointers←0, `expected_pc`←`redirect_pc` with bit 0 cleared, `skip_low`←`redirect_pc[1]`. Redirect overrides any same-cycle push or pop; a same-cycle fetch word is dropped. `out_valid` is not masked in the redirect cycle; the consumer ignores it.

## Timing
- Reset (sync, active-high): `count`=0, `expected_pc`=`RESET_PC`, `skip_low`=`RESET_PC[1]`. Outputs during and after reset: `out_valid`=0, `out_instruction`=0, `out_pc`=0, `out_is_compressed`=0, `out_illegal`=0. `fetch_ready`=0 while `rst`=1 and 1 in the first cycle after it.
- Outputs are combinational from the registered buffer head. A word accepted at edge N is visible at `out_*` after edge N, with no combinational path from fetch to out.
- Throughput: one instruction per cycle while the buffer holds enough entries.
- A 32-bit instruction split across words is presented only after both words have been pushed.
- While `out_valid && !out_ready`, every `out_*` signal holds stable.
- Pointers wrap modulo `BUF_HALFWORDS`.
- Redirect: the first output is at least 1 cycle after the first matching accept.

## Test plan
- Reset then idle -> `out_valid`=0 and `fetch_ready`=0 during `rst`; `fetch_ready`=1 on the next cycle.
- Word 0x00A00093 at 0x0 -> next cycle `out_instruction`=0x00A00093, `out_pc`=0x0, `out_is_compressed`=0.
- Word 0x45054501 at 0x0 -> two outputs: 0x00000513 at pc 0x0, then 0x00100513 at pc 0x2, both with `out_is_compressed`=1.
- Words 0x00934501 at 0x0 and 0x450500A0 at 0x4 -> outputs 0x00000513 at pc 0x0, 0x00A00093 at pc 0x2 (not before the second word is accepted), then 0x00100513 at pc 0x6.
- Redirect to 0x102, then a stale word at 0x8, then 0x4505FFFF at 0x100 -> stale word accepted and dropped; single output 0x00100513 at pc 0x102.
- Halfword 0x0000 plus `out_ready`=0 for 5 cycles with continuous fetch -> `out_illegal`=1 and `out_instruction`=0x00000000 held stable; `fetch_ready` falls once free entries < 2; after release the next pc is +2.
